// File: rtl/lsu_dccm_wr_arb.sv
// DCCM write-port arbiter: scalar LSU stores vs. multi-beat strided vector stores, with starvation bounds.
// Optional RV_DCCM_ARB_PERF_EN adds vs_stall_cnt (RUN cycles where vector data waits on the scalar).
module lsu_dccm_wr_arb #(
   parameter int DCCM_BITS  = 16,
   parameter int DATA_W     = 39,
   parameter int MAX_BEATS  = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic                           clk,
   input  logic                           rst_l,
   input  logic                           freeze,
   input  logic                           sc_wr_valid,
   output logic                           sc_wr_ready,
   input  logic [DCCM_BITS-1:0]           sc_wr_addr,
   input  logic [DATA_W-1:0]              sc_wr_data,
   input  logic                           vs_req_valid,
   output logic                           vs_req_ready,
   input  logic [DCCM_BITS-1:0]           vs_base_addr,
   input  logic [DCCM_BITS-1:0]           vs_stride,
   input  logic [$clog2(MAX_BEATS):0]     vs_beats,
   input  logic                           vs_data_valid,
   output logic                           vs_data_ready,
   input  logic [DATA_W-1:0]              vs_data,
   output logic                           vs_done,
   output logic                           dccm_wren,
   output logic [DCCM_BITS-1:0]           dccm_wr_addr,
   output logic [DATA_W-1:0]              dccm_wr_data,
   output logic                           is_vector_store,
`ifdef RV_DCCM_ARB_PERF_EN
   output logic [15:0]                    vs_stall_cnt,
`endif
   output logic                           busy,
   output logic [1:0]                     dbg_state
);

   localparam int BW = $clog2(MAX_BEATS) + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);

   // Handshake rule: a transfer happens only in a cycle where valid and ready are both high;
   // readys are combinational from state and valids, and all are forced low while freeze is high.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t               state;
   logic [DCCM_BITS-1:0] acc_addr;
   logic [DCCM_BITS-1:0] stride;
   logic [BW-1:0]        beats;
   logic [BW-1:0]        idx;
   logic [SW-1:0]        starve_v;
   logic [SW-1:0]        starve_s;
   logic [BW-1:0]        beats_in;
   logic                 sv_sat;
   logic                 ss_sat;
   logic                 sc_acc;
   logic                 vd_acc;

   assign beats_in  = (vs_beats > BW'(MAX_BEATS)) ? BW'(MAX_BEATS) : vs_beats;
   assign sv_sat    = (starve_v == SW'(STARVE_MAX));
   assign ss_sat    = (starve_s == SW'(STARVE_MAX));
   assign sc_acc    = sc_wr_valid && sc_wr_ready;
   assign vd_acc    = vs_data_valid && vs_data_ready;
   assign busy      = (state != IDLE);
   assign dbg_state = state;

   always_comb begin
      vs_req_ready  = 1'b0;
      vs_data_ready = 1'b0;
      sc_wr_ready   = 1'b0;
      if (!freeze) begin
         case (state)
            IDLE: begin
               vs_req_ready = vs_req_valid && (!sc_wr_valid || sv_sat);
               sc_wr_ready  = sc_wr_valid && !vs_req_ready;
            end
            RUN: begin
               vs_data_ready = vs_data_valid && !(sc_wr_valid && ss_sat);
               sc_wr_ready   = sc_wr_valid && !vs_data_ready;
            end
            DONE:    sc_wr_ready = sc_wr_valid;
            default: sc_wr_ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_l) begin
         state           <= IDLE;
         acc_addr        <= '0;
         stride          <= '0;
         beats           <= '0;
         idx             <= '0;
         starve_v        <= '0;
         starve_s        <= '0;
         vs_done         <= 1'b0;
         dccm_wren       <= 1'b0;
         dccm_wr_addr    <= '0;
         dccm_wr_data    <= '0;
         is_vector_store <= 1'b0;
      end else begin
         dccm_wren       <= sc_acc || vd_acc;
         is_vector_store <= vd_acc;
         vs_done         <= (state == DONE) && !freeze;
         if (vd_acc) begin
            dccm_wr_addr <= acc_addr;
            dccm_wr_data <= vs_data;
         end else if (sc_acc) begin
            dccm_wr_addr <= sc_wr_addr;
            dccm_wr_data <= sc_wr_data;
         end

         // Scalar wait is measured in vector beats it lost; any scalar grant ends the wait.
         if (sc_acc)
            starve_s <= '0;
         else if (vd_acc && sc_wr_valid && !ss_sat)
            starve_s <= starve_s + SW'(1);

         case (state)
            IDLE: begin
               if (vs_req_ready) begin
                  acc_addr <= vs_base_addr;
                  stride   <= vs_stride;
                  beats    <= beats_in;
                  idx      <= '0;
                  starve_v <= '0;
                  state    <= (beats_in == '0) ? DONE : RUN;
               end else if (!freeze && vs_req_valid && !sv_sat) begin
                  starve_v <= starve_v + SW'(1);
               end
            end
            RUN: begin
               if (vd_acc) begin
                  acc_addr <= acc_addr + stride;
                  idx      <= idx + BW'(1);
                  if (idx == beats - BW'(1))
                     state <= DONE;
               end
            end
            DONE: begin
               if (!freeze)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RV_DCCM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_l || vs_req_ready)
         vs_stall_cnt <= '0;
      else if ((state == RUN) && vs_data_valid && !vs_data_ready && !freeze && (vs_stall_cnt != 16'hFFFF))
         vs_stall_cnt <= vs_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_lsu_dccm_wr_arb.sv
// Directed bench for lsu_dccm_wr_arb: scalar path, strided vectors, wrap, starvation, freeze, zero beats, reset.
module tb_lsu_dccm_wr_arb;

   logic        clk = 1'b0;
   logic        rst_l;
   logic        freeze;
   logic        sc_wr_valid;
   logic        sc_wr_ready;
   logic [15:0] sc_wr_addr;
   logic [38:0] sc_wr_data;
   logic        vs_req_valid;
   logic        vs_req_ready;
   logic [15:0] vs_base_addr;
   logic [15:0] vs_stride;
   logic [3:0]  vs_beats;
   logic        vs_data_valid;
   logic        vs_data_ready;
   logic [38:0] vs_data;
   logic        vs_done;
   logic        dccm_wren;
   logic [15:0] dccm_wr_addr;
   logic [38:0] dccm_wr_data;
   logic        is_vector_store;
   logic        busy;
   logic [1:0]  dbg_state;
`ifdef RV_DCCM_ARB_PERF_EN
   logic [15:0] vs_stall_cnt;
`endif

   int n_checks = 0;
   int n_err    = 0;

   lsu_dccm_wr_arb dut (
      .clk(clk), .rst_l(rst_l), .freeze(freeze),
      .sc_wr_valid(sc_wr_valid), .sc_wr_ready(sc_wr_ready),
      .sc_wr_addr(sc_wr_addr), .sc_wr_data(sc_wr_data),
      .vs_req_valid(vs_req_valid), .vs_req_ready(vs_req_ready),
      .vs_base_addr(vs_base_addr), .vs_stride(vs_stride), .vs_beats(vs_beats),
      .vs_data_valid(vs_data_valid), .vs_data_ready(vs_data_ready), .vs_data(vs_data),
      .vs_done(vs_done), .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr),
      .dccm_wr_data(dccm_wr_data), .is_vector_store(is_vector_store),
`ifdef RV_DCCM_ARB_PERF_EN
      .vs_stall_cnt(vs_stall_cnt),
`endif
      .busy(busy), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic vec_start(input logic [15:0] base, input logic [15:0] str, input logic [3:0] nb);
      vs_req_valid = 1'b1;
      vs_base_addr = base;
      vs_stride    = str;
      vs_beats     = nb;
      #1;
      chk("vs_req_ready", vs_req_ready, 1);
      cyc();
      vs_req_valid  = 1'b0;
      vs_data_valid = 1'b1;
      chk("busy_after_req", busy, 1);
      chk("state_run", dbg_state, 1);
   endtask

   task automatic vec_beat(input logic [15:0] exp_addr, input logic [38:0] d);
      vs_data = d;
      #1;
      chk("vs_data_ready", vs_data_ready, 1);
      cyc();
      chk("beat_wren", dccm_wren, 1);
      chk("beat_addr", dccm_wr_addr, exp_addr);
      chk("beat_data", dccm_wr_data, d);
      chk("beat_is_vec", is_vector_store, 1);
   endtask

   task automatic vec_finish();
      vs_data_valid = 1'b0;
      chk("done_not_yet", vs_done, 0);
      cyc();
      chk("done_pulse", vs_done, 1);
      chk("done_busy", busy, 0);
      chk("done_wren", dccm_wren, 0);
      cyc();
      chk("done_clear", vs_done, 0);
   endtask

   initial begin
      rst_l = 1'b0; freeze = 1'b0;
      sc_wr_valid = 1'b0; sc_wr_addr = '0; sc_wr_data = '0;
      vs_req_valid = 1'b0; vs_base_addr = '0; vs_stride = '0; vs_beats = '0;
      vs_data_valid = 1'b0; vs_data = '0;
      repeat (3) cyc();
      chk("rst_wren", dccm_wren, 0);
      chk("rst_addr", dccm_wr_addr, 0);
      chk("rst_data", dccm_wr_data, 0);
      chk("rst_is_vec", is_vector_store, 0);
      chk("rst_done", vs_done, 0);
      chk("rst_busy", busy, 0);
      rst_l = 1'b1;
      cyc();

      // scalar only
      sc_wr_valid = 1'b1; sc_wr_addr = 16'h0040; sc_wr_data = 39'h12345678A;
      #1;
      chk("sc_ready", sc_wr_ready, 1);
      cyc();
      chk("sc_wren", dccm_wren, 1);
      chk("sc_addr", dccm_wr_addr, 16'h0040);
      chk("sc_data", dccm_wr_data, 39'h12345678A);
      chk("sc_is_vec", is_vector_store, 0);
      sc_wr_valid = 1'b0;
      cyc();
      chk("sc_idle_wren", dccm_wren, 0);

      // three-beat vector
      vec_start(16'h0100, 16'h0004, 4'd3);
      vec_beat(16'h0100, 39'h0A0);
      vec_beat(16'h0104, 39'h0A1);
      vec_beat(16'h0108, 39'h0A2);
      vec_finish();

      // address wrap, then negative stride
      vec_start(16'hFFFC, 16'h0004, 4'd2);
      vec_beat(16'hFFFC, 39'h0B0);
      vec_beat(16'h0000, 39'h0B1);
      vec_finish();
      vec_start(16'h0008, 16'hFFFC, 4'd3);
      vec_beat(16'h0008, 39'h0C0);
      vec_beat(16'h0004, 39'h0C1);
      vec_beat(16'h0000, 39'h0C2);
      vec_finish();

      // scalar starving against an 8-beat vector
      vec_start(16'h0200, 16'h0001, 4'd8);
      sc_wr_valid = 1'b1; sc_wr_addr = 16'h0300; sc_wr_data = 39'h3300;
      vec_beat(16'h0200, 39'h0D0);
      vec_beat(16'h0201, 39'h0D1);
      vec_beat(16'h0202, 39'h0D2);
      vec_beat(16'h0203, 39'h0D3);
      #1;
      chk("starve_s_vec_blocked", vs_data_ready, 0);
      chk("starve_s_sc_ready", sc_wr_ready, 1);
      cyc();
      chk("starve_s_wren", dccm_wren, 1);
      chk("starve_s_addr", dccm_wr_addr, 16'h0300);
      chk("starve_s_is_vec", is_vector_store, 0);
      vec_beat(16'h0204, 39'h0D4);
      vec_beat(16'h0205, 39'h0D5);
      vec_beat(16'h0206, 39'h0D6);
      vec_beat(16'h0207, 39'h0D7);
      vs_data_valid = 1'b0;
      #1;
      chk("done_sc_ready", sc_wr_ready, 1);
      cyc();
      chk("done_sc_wren", dccm_wren, 1);
      chk("done_sc_addr", dccm_wr_addr, 16'h0300);
      chk("done_sc_is_vec", is_vector_store, 0);
      chk("done_sc_pulse", vs_done, 1);
      sc_wr_valid = 1'b0;
      cyc();
      chk("done_sc_clear", vs_done, 0);

      // vector request starving against continuous scalar
      sc_wr_valid = 1'b1; sc_wr_addr = 16'h0400; sc_wr_data = 39'h4400;
      vs_req_valid = 1'b1; vs_base_addr = 16'h0500; vs_stride = 16'h0008; vs_beats = 4'd1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("starve_v_req_wait", vs_req_ready, 0);
         chk("starve_v_sc_ready", sc_wr_ready, 1);
         cyc();
         chk("starve_v_sc_wren", dccm_wren, 1);
      end
      #1;
      chk("starve_v_req_ready", vs_req_ready, 1);
      chk("starve_v_sc_held", sc_wr_ready, 0);
      cyc();
      chk("starve_v_no_wren", dccm_wren, 0);
      chk("starve_v_busy", busy, 1);
      sc_wr_valid = 1'b0; vs_req_valid = 1'b0; vs_data_valid = 1'b1;
      vec_beat(16'h0500, 39'h0E0);
      vec_finish();

      // freeze mid-run
      vec_start(16'h0600, 16'h0010, 4'd4);
      vec_beat(16'h0600, 39'h0F0);
      vec_beat(16'h0610, 39'h0F1);
      freeze = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("frz_ready", vs_data_ready, 0);
         cyc();
         chk("frz_wren", dccm_wren, 0);
         chk("frz_busy", busy, 1);
      end
      freeze = 1'b0;
      vec_beat(16'h0620, 39'h0F2);
      vec_beat(16'h0630, 39'h0F3);
      vec_finish();

      // zero beats
      vs_req_valid = 1'b1; vs_base_addr = 16'h0700; vs_stride = 16'h0004; vs_beats = 4'd0;
      #1;
      chk("zb_req_ready", vs_req_ready, 1);
      cyc();
      vs_req_valid = 1'b0;
      chk("zb_wren0", dccm_wren, 0);
      chk("zb_done0", vs_done, 0);
      chk("zb_busy0", busy, 1);
      cyc();
      chk("zb_done1", vs_done, 1);
      chk("zb_wren1", dccm_wren, 0);
      chk("zb_busy1", busy, 0);
      cyc();
      chk("zb_done2", vs_done, 0);

      // beat count above MAX_BEATS clamps to 8
      vec_start(16'h0800, 16'h0002, 4'd15);
      for (int i = 0; i < 8; i++)
         vec_beat(16'h0800 + 16'(2 * i), 39'h100 + 39'(i));
      vec_finish();

      // reset mid-run
      vec_start(16'h0900, 16'h0004, 4'd4);
      vec_beat(16'h0900, 39'h1A0);
      rst_l = 1'b0;
      cyc();
      chk("mrst_wren", dccm_wren, 0);
      chk("mrst_addr", dccm_wr_addr, 0);
      chk("mrst_data", dccm_wr_data, 0);
      chk("mrst_is_vec", is_vector_store, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", vs_done, 0);
      vs_data_valid = 1'b0;
      rst_l = 1'b1;
      cyc();
      chk("mrst_done_after", vs_done, 0);
      chk("mrst_wren_after", dccm_wren, 0);
      chk("mrst_busy_after", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
